// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared mode encodings and PC increment for the PC step sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        MODE_PAUSE = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_HALT  = 2'd2
    } mode_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_step_sequencer_button_conditioner.sv
// rtl/pc_step_sequencer_button_conditioner.sv - raw button synchronizer, debouncer and press pulse
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync0_d = btn_raw;
        sync1_d = sync0_q;
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the debounced level restarts the stability count.
        if (sync1_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        prev_d  = level_q;
        pulse_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/pc_step_sequencer.sv
// rtl/pc_step_sequencer.sv - PC advance sequencer: single step, free run, breakpoint and halt
module pc_step_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_btn,
    input  logic                run_btn,
    input  logic                halt_req,
    input  logic [PC_WIDTH-1:0] current_pc,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                bp_en,
    input  logic [PC_WIDTH-1:0] bp_addr,
    output logic                pc_en,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [1:0]          mode,
    output logic [15:0]         adv_count
);

    localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

    logic                step_p, run_p;
    logic [PC_WIDTH-1:0] pc_sel;
    mode_e               state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic                pc_en_q, pc_en_d;
    logic [15:0]         adv_count_q, adv_count_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (step_btn),
        .btn_pulse (step_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (run_btn),
        .btn_pulse (run_p)
    );

    always_comb begin
        if (jump) begin
            pc_sel = jump_target;
        end else if (branch_taken) begin
            pc_sel = branch_target;
        end else begin
            pc_sel = current_pc + PC_WIDTH'(PC_STEP);
        end
        next_pc = pc_sel & ~PC_WIDTH'(3);
    end

    // Event priority is halt_req, then run_p, then step_p; a losing step is dropped.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        pc_en_d     = 1'b0;
        adv_count_d = adv_count_q + {15'd0, pc_en_q};
        if (halt_req) begin
            state_d = MODE_HALT;
        end else begin
            case (state_q)
                MODE_PAUSE: begin
                    if (run_p) begin
                        state_d = MODE_RUN;
                        div_d   = '0;
                    end else if (step_p) begin
                        pc_en_d = 1'b1;
                    end
                end
                MODE_RUN: begin
                    if (run_p) begin
                        state_d = MODE_PAUSE;
                    end else if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        pc_en_d = 1'b1;
                        if (bp_en && (next_pc == bp_addr)) begin
                            state_d = MODE_HALT;
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                MODE_HALT: begin
                    if (run_p) begin
                        state_d = MODE_RUN;
                        div_d   = '0;
                    end else if (step_p) begin
                        pc_en_d = 1'b1;
                        state_d = MODE_PAUSE;
                    end
                end
                default: state_d = MODE_PAUSE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MODE_PAUSE;
            div_q       <= '0;
            pc_en_q     <= 1'b0;
            adv_count_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pc_en_q     <= pc_en_d;
            adv_count_q <= adv_count_d;
        end
    end

    assign pc_en     = pc_en_q;
    assign mode      = state_q;
    assign adv_count = adv_count_q;

endmodule

// File: tb/tb_pc_step_sequencer.sv
// tb/tb_pc_step_sequencer.sv - bench for pc_step_sequencer against a windowed behavioural model
module tb_pc_step_sequencer;

    localparam int DC = 4;
    localparam int RD = 3;
    localparam int NE = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] current_pc = 32'd0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] bp_addr = 32'd0;
    logic        pc_en;
    logic [31:0] next_pc;
    logic [1:0]  mode;
    logic [15:0] adv_count;

    always #5 clk = ~clk;

    pc_step_sequencer #(.PC_WIDTH(32), .DEBOUNCE_CYCLES(DC), .RUN_DIV(RD)) dut (
        .clk           (clk),
        .reset         (reset),
        .step_btn      (step_btn),
        .run_btn       (run_btn),
        .halt_req      (halt_req),
        .current_pc    (current_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .pc_en         (pc_en),
        .next_pc       (next_pc),
        .mode          (mode),
        .adv_count     (adv_count)
    );

    int checks = 0;
    int passes = 0;
    int n = 0;
    bit raw_h [2][NE];
    bit rise_at [2][NE];
    int last_flip [2];
    bit dbl [2];
    int m_mode = 0;
    bit m_en = 0;
    int m_adv = 0;
    int run_start = 0;
    logic [31:0] sq[$];
    int se[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", nm, act, exp, n);
    endtask

    function automatic logic [31:0] ref_next();
        logic [31:0] t;
        if (jump) t = jump_target;
        else if (branch_taken) t = branch_target;
        else t = current_pc + 32'd4;
        return {t[31:2], 2'b00};
    endfunction

    // Debounced level flips once the last DC compared samples all disagree with it
    // and at least DC edges have passed since the previous flip or reset.
    task automatic button_edge(input int b, input bit raw);
        bit f;
        bit v;
        raw_h[b][n] = raw;
        f = 1'b0;
        if (n - last_flip[b] >= DC) begin
            f = 1'b1;
            for (int j = n - DC + 1; j <= n; j++) begin
                v = (j >= 2) ? raw_h[b][j-2] : 1'b0;
                if (v == dbl[b]) f = 1'b0;
            end
        end
        rise_at[b][n] = f && !dbl[b];
        if (f) begin
            dbl[b] = !dbl[b];
            last_flip[b] = n;
        end
    endtask

    task automatic model_edge();
        bit sp, rp, en_old;
        logic [31:0] np_old;
        np_old = ref_next();
        en_old = m_en;
        sp = (n >= 2) && rise_at[0][n-2];
        rp = (n >= 2) && rise_at[1][n-2];
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                raw_h[b][n] = 1'b0;
                rise_at[b][n] = 1'b0;
                if (n >= 1) begin
                    raw_h[b][n-1] = 1'b0;
                    rise_at[b][n-1] = 1'b0;
                end
                dbl[b] = 1'b0;
                last_flip[b] = n;
            end
            m_mode = 0;
            m_en = 1'b0;
            m_adv = 0;
            current_pc = 32'd0;
        end else begin
            button_edge(0, step_btn);
            button_edge(1, run_btn);
            m_en = 1'b0;
            if (halt_req) m_mode = 2;
            else if (m_mode == 0) begin
                if (rp) begin m_mode = 1; run_start = n; end
                else if (sp) m_en = 1'b1;
            end else if (m_mode == 1) begin
                if (rp) m_mode = 0;
                else if ((n - run_start) % RD == 0) begin
                    m_en = 1'b1;
                    if (bp_en && np_old == bp_addr) m_mode = 2;
                end
            end else begin
                if (rp) begin m_mode = 1; run_start = n; end
                else if (sp) begin m_en = 1'b1; m_mode = 0; end
            end
            m_adv = (m_adv + int'(en_old)) % 65536;
            if (en_old) current_pc = np_old;
        end
        n++;
    endtask

    task automatic tick();
        #1;
        chk("next_pc", next_pc, ref_next());
        @(posedge clk);
        #1;
        model_edge();
        chk("pc_en", pc_en, m_en);
        chk("mode", mode, m_mode);
        chk("adv_count", adv_count, m_adv);
        if (pc_en) begin
            sq.push_back(current_pc);
            se.push_back(n - 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press(input int b, input int hold, input int settle);
        if (b == 0) step_btn = 1'b1; else run_btn = 1'b1;
        repeat (hold) tick();
        if (b == 0) step_btn = 1'b0; else run_btn = 1'b0;
        repeat (settle) tick();
    endtask

    int cnt, first;
    logic [31:0] np_at;
    int hold [2];
    bit found;

    initial begin
        do_reset();
        chk("reset_mode", mode, 0);
        chk("reset_adv", adv_count, 0);
        chk("reset_pc_en", pc_en, 0);
        #1 chk("s1_np_idle", next_pc, 32'h4);

        step_btn = 1'b1;
        cnt = 0; first = -1; np_at = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pc_en) begin
                cnt++;
                if (first < 0) begin first = k; np_at = next_pc; end
            end
        end
        chk("s1_strobes", cnt, 1);
        chk("s1_strobe_cycle", first, 7);
        chk("s1_np", np_at, 32'h4);
        chk("s1_adv", adv_count, 1);
        chk("s1_mode", mode, 0);
        step_btn = 1'b0;
        repeat (10) tick();

        sq.delete();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) step_btn = ~step_btn;
            tick();
        end
        step_btn = 1'b0;
        repeat (10) tick();
        chk("s2_strobes", sq.size(), 0);
        chk("s2_adv", adv_count, 1);

        do_reset();
        sq.delete(); se.delete();
        press(1, 8, 16);
        chk("s3_mode_run", mode, 1);
        chk("s3_enough", sq.size() >= 4, 1);
        for (int i = 0; i < 4 && i < sq.size(); i++) chk("s3_pc", sq[i], 4 * i);
        if (se.size() >= 2) chk("s3_spacing", se[1] - se[0], 3);
        press(1, 8, 2);
        sq.delete();
        repeat (10) tick();
        chk("s3_paused_strobes", sq.size(), 0);
        chk("s3_mode_pause", mode, 0);

        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10;
        sq.delete();
        press(1, 8, 20);
        chk("s4_mode_halt", mode, 2);
        chk("s4_pc", current_pc, 32'h10);
        chk("s4_strobes", sq.size(), 4);
        press(0, 8, 8);
        chk("s4_step_pc", current_pc, 32'h14);
        chk("s4_step_mode", mode, 0);
        bp_en = 1'b0;

        jump = 1'b1; jump_target = 32'h43; branch_taken = 1'b1; branch_target = 32'h200;
        #1 chk("s5_jump_np", next_pc, 32'h40);
        press(0, 8, 8);
        chk("s5_jump_pc", current_pc, 32'h40);
        jump = 1'b0; branch_taken = 1'b0; current_pc = 32'hFFFF_FFFC;
        #1 chk("s5_wrap_np", next_pc, 32'h0);

        do_reset();
        press(1, 8, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (pc_en) found = 1'b1;
        end
        chk("s6_run_strobe_seen", found, 1);
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        chk("s6_halt_pc_en", pc_en, 0);
        chk("s6_halt_mode", mode, 2);
        halt_req = 1'b0;
        tick();

        do_reset();
        step_btn = 1'b1; run_btn = 1'b1;
        repeat (8) tick();
        chk("s6_both_mode", mode, 1);
        chk("s6_both_adv", adv_count, 0);
        step_btn = 1'b0; run_btn = 1'b0;
        repeat (8) tick();

        do_reset();
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    if (b == 0) step_btn = 1'($urandom_range(0, 1));
                    else run_btn = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 4);
                end
                hold[b]--;
            end
            halt_req = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 499) == 0);
            jump = ($urandom_range(0, 15) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            jump_target = $urandom;
            branch_target = $urandom;
            if (c % 50 == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = current_pc + 32'(4 * $urandom_range(1, 6));
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
